// File: rtl/sisc_ctrl_mc_if.sv
// Datapath-side bundle of the SISC multicycle controller: instruction/status
// fields in, datapath strobes and status out.
interface sisc_ctrl_mc_if #(
   parameter int OP_W   = 4,
   parameter int MM_W   = 4,
   parameter int STAT_W = 4,
   parameter int FN_W   = 4,
   parameter int CNT_W  = 16
);
   logic [OP_W-1:0]   opcode;
   logic [MM_W-1:0]   mm;
   logic [FN_W-1:0]   func;
   logic [STAT_W-1:0] stat;
   logic              mem_ack;

   logic              ir_load;
   logic              pc_write;
   logic              stat_en;
   logic              rf_we;
   logic              rf_wsel;
   logic              alu_imm;
   logic              mem_req;
   logic              mem_we;
   logic              wb_sel;
   logic [1:0]        pc_sel;
   logic [FN_W-1:0]   alu_op;
   logic              halted;
   logic              fault;
   logic              retire;
   logic [CNT_W-1:0]  retire_cnt;

   modport master (
      input  opcode, mm, func, stat, mem_ack,
      output ir_load, pc_write, stat_en, rf_we, rf_wsel, alu_imm, mem_req, mem_we,
             wb_sel, pc_sel, alu_op, halted, fault, retire, retire_cnt
   );

   modport slave (
      output opcode, mm, func, stat, mem_ack,
      input  ir_load, pc_write, stat_en, rf_we, rf_wsel, alu_imm, mem_req, mem_we,
             wb_sel, pc_sel, alu_op, halted, fault, retire, retire_cnt
   );
endinterface

// File: rtl/sisc_ctrl_mc.sv
// Multicycle control FSM for SISC: wait-state memory handshake with timeout,
// status-mask branches, LOD/STR sequencing, two-cycle SWAP writeback.
module sisc_ctrl_mc #(
   parameter int OP_W        = 4,
   parameter int MM_W        = 4,
   parameter int STAT_W      = 4,
   parameter int FN_W        = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input logic              clk,
   input logic              rst_f,
   sisc_ctrl_mc_if.master   bus
);

   localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

   localparam logic [OP_W-1:0] OP_NOOP   = OP_W'(0);
   localparam logic [OP_W-1:0] OP_REG_OP = OP_W'(1);
   localparam logic [OP_W-1:0] OP_REG_IM = OP_W'(2);
   localparam logic [OP_W-1:0] OP_SWAP   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_BRA    = OP_W'(4);
   localparam logic [OP_W-1:0] OP_BRR    = OP_W'(5);
   localparam logic [OP_W-1:0] OP_BNE    = OP_W'(6);
   localparam logic [OP_W-1:0] OP_BNR    = OP_W'(7);
   localparam logic [OP_W-1:0] OP_JPA    = OP_W'(8);
   localparam logic [OP_W-1:0] OP_JPR    = OP_W'(9);
   localparam logic [OP_W-1:0] OP_LOD    = OP_W'(10);
   localparam logic [OP_W-1:0] OP_STR    = OP_W'(11);
   localparam logic [OP_W-1:0] OP_HLT    = OP_W'(15);

   typedef enum logic [3:0] {
      S_START, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_WB2, S_HALT, S_FAULT
   } state_t;

   state_t            state;
   logic [OP_W-1:0]   op_q;
   logic [MM_W-1:0]   mm_q;
   logic [FN_W-1:0]   fn_q;
   logic [WAIT_W-1:0] wait_cnt;
   logic [CNT_W-1:0]  cnt_q;
   logic [STAT_W-1:0] hit;
   logic              taken;
   logic              timeout;

   assign bus.retire_cnt = cnt_q;

   // Branch condition uses the live status register against the latched mask.
   always_comb begin
      hit   = bus.stat & mm_q;
      taken = 1'b0;
      case (op_q)
         OP_BRA, OP_BRR: taken = |hit;
         OP_BNE, OP_BNR: taken = ~|hit;
         OP_JPA, OP_JPR: taken = 1'b1;
         default:        taken = 1'b0;
      endcase
   end

   assign timeout = (MEM_TIMEOUT > 0) && !bus.mem_ack &&
                    (wait_cnt == WAIT_W'(MEM_TIMEOUT));

   always_comb begin
      bus.ir_load  = 1'b0;
      bus.pc_write = 1'b0;
      bus.stat_en  = 1'b0;
      bus.rf_we    = 1'b0;
      bus.rf_wsel  = 1'b0;
      bus.alu_imm  = 1'b0;
      bus.mem_req  = 1'b0;
      bus.mem_we   = 1'b0;
      bus.wb_sel   = 1'b0;
      bus.pc_sel   = 2'd0;
      bus.alu_op   = '0;
      bus.halted   = 1'b0;
      bus.fault    = 1'b0;
      bus.retire   = 1'b0;
      case (state)
         S_FETCH: begin
            bus.mem_req  = 1'b1;
            bus.ir_load  = bus.mem_ack;
            bus.pc_write = bus.mem_ack;
         end
         S_EXECUTE: begin
            case (op_q)
               OP_REG_OP, OP_REG_IM: begin
                  bus.alu_op  = fn_q;
                  bus.stat_en = 1'b1;
                  bus.alu_imm = (op_q == OP_REG_IM);
               end
               OP_LOD, OP_STR: bus.alu_imm = 1'b1;
               OP_BRA, OP_BRR, OP_BNE, OP_BNR, OP_JPA, OP_JPR: begin
                  bus.pc_write = taken;
                  if (taken)
                     bus.pc_sel = (op_q == OP_BRA || op_q == OP_BNE || op_q == OP_JPA) ?
                                  2'd1 : 2'd2;
                  bus.retire = 1'b1;
               end
               OP_NOOP: bus.retire = 1'b1;
               default: ;
            endcase
         end
         S_MEM: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = (op_q == OP_STR);
            bus.retire  = bus.mem_ack && (op_q == OP_STR);
         end
         S_WB: begin
            bus.rf_we  = 1'b1;
            bus.wb_sel = (op_q == OP_LOD);
            bus.retire = (op_q != OP_SWAP);
         end
         S_WB2: begin
            bus.rf_we   = 1'b1;
            bus.rf_wsel = 1'b1;
            bus.retire  = 1'b1;
         end
         S_HALT:  bus.halted = 1'b1;
         S_FAULT: bus.fault  = 1'b1;
         default: ;
      endcase
   end

   // Wait counter is zero whenever FETCH or MEM is entered; it only counts
   // un-acked cycles while sitting in one of those states.
   always_ff @(posedge clk) begin
      if (rst_f) begin
         state    <= S_START;
         cnt_q    <= '0;
         op_q     <= '0;
         mm_q     <= '0;
         fn_q     <= '0;
         wait_cnt <= '0;
      end else begin
         if (bus.retire)
            cnt_q <= cnt_q + 1'b1;
         wait_cnt <= '0;
         case (state)
            S_START: state <= S_FETCH;
            S_FETCH: begin
               if (bus.mem_ack)  state <= S_DECODE;
               else if (timeout) state <= S_FAULT;
               else              wait_cnt <= wait_cnt + 1'b1;
            end
            S_DECODE: begin
               op_q <= bus.opcode;
               mm_q <= bus.mm;
               fn_q <= bus.func;
               case (bus.opcode)
                  OP_HLT: state <= S_HALT;
                  OP_NOOP, OP_REG_OP, OP_REG_IM, OP_SWAP, OP_BRA, OP_BRR, OP_BNE,
                  OP_BNR, OP_JPA, OP_JPR, OP_LOD, OP_STR: state <= S_EXECUTE;
                  default: state <= S_FAULT;
               endcase
            end
            S_EXECUTE: begin
               case (op_q)
                  OP_REG_OP, OP_REG_IM, OP_SWAP: state <= S_WB;
                  OP_LOD, OP_STR:                state <= S_MEM;
                  default:                       state <= S_FETCH;
               endcase
            end
            S_MEM: begin
               if (bus.mem_ack)  state <= (op_q == OP_STR) ? S_FETCH : S_WB;
               else if (timeout) state <= S_FAULT;
               else              wait_cnt <= wait_cnt + 1'b1;
            end
            S_WB:    state <= (op_q == OP_SWAP) ? S_WB2 : S_FETCH;
            S_WB2:   state <= S_FETCH;
            S_HALT:  state <= S_HALT;
            S_FAULT: state <= S_FAULT;
            default: state <= S_FAULT;
         endcase
      end
   end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// Directed bench for sisc_ctrl_mc: one task per scenario, expected values
// hand-derived from the instruction cycle sequences.
module tb_sisc_ctrl_mc;
   logic clk;
   logic rst_f;
   int   n_cmp;
   int   n_fail;

   sisc_ctrl_mc_if #(.CNT_W(4)) bus ();

   sisc_ctrl_mc #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_f (rst_f),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ends in START with rst_f low; the next tick enters FETCH.
   task automatic do_reset();
      rst_f = 1'b1;
      bus.opcode = '0; bus.mm = '0; bus.func = '0; bus.stat = '0; bus.mem_ack = 1'b0;
      repeat (3) tick();
      rst_f = 1'b0;
   endtask

   // From the state preceding FETCH: one acked FETCH cycle, ends in DECODE.
   task automatic fetch_decode(input logic [3:0] op, input logic [3:0] m, input logic [3:0] f);
      bus.opcode = op; bus.mm = m; bus.func = f;
      tick();
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
      n_cmp++; if (bus.retire_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.retire_cnt); end
      n_cmp++; if ({bus.halted, bus.fault, bus.retire, bus.ir_load} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.halted, bus.fault, bus.retire, bus.ir_load}); end
   endtask

   task automatic test_reg_op();
      do_reset();
      bus.opcode = 4'd1; bus.func = 4'd4;
      tick();  // cycle 1: FETCH
      bus.mem_ack = 1'b1; #1;
      n_cmp++; if ({bus.mem_req, bus.mem_we, bus.ir_load, bus.pc_write} !== 4'b1011) begin n_fail++; $display("FAIL regop_fetch: got %b want 1011", {bus.mem_req, bus.mem_we, bus.ir_load, bus.pc_write}); end
      n_cmp++; if (bus.pc_sel !== 2'd0) begin n_fail++; $display("FAIL regop_fetch_pcsel: got %0d want 0", bus.pc_sel); end
      tick();  // cycle 2: DECODE
      bus.mem_ack = 1'b0; #1;
      n_cmp++; if ({bus.mem_req, bus.stat_en, bus.rf_we} !== 3'b000) begin n_fail++; $display("FAIL regop_decode: got %b want 000", {bus.mem_req, bus.stat_en, bus.rf_we}); end
      tick();  // cycle 3: EXECUTE
      n_cmp++; if ({bus.stat_en, bus.alu_imm, bus.rf_we} !== 3'b100) begin n_fail++; $display("FAIL regop_exec: got %b want 100", {bus.stat_en, bus.alu_imm, bus.rf_we}); end
      n_cmp++; if (bus.alu_op !== 4'd4) begin n_fail++; $display("FAIL regop_aluop: got %0d want 4", bus.alu_op); end
      tick();  // cycle 4: WB
      n_cmp++; if ({bus.rf_we, bus.rf_wsel, bus.wb_sel, bus.retire} !== 4'b1001) begin n_fail++; $display("FAIL regop_wb: got %b want 1001", {bus.rf_we, bus.rf_wsel, bus.wb_sel, bus.retire}); end
      tick();  // back to FETCH
      n_cmp++; if (bus.retire_cnt !== 4'd1) begin n_fail++; $display("FAIL regop_cnt: got %0d want 1", bus.retire_cnt); end
      n_cmp++; if ({bus.mem_req, bus.rf_we} !== 2'b10) begin n_fail++; $display("FAIL regop_refetch: got %b want 10", {bus.mem_req, bus.rf_we}); end
   endtask

   task automatic test_reg_im();
      do_reset();
      fetch_decode(4'd2, 4'd0, 4'd9);
      tick();
      n_cmp++; if ({bus.stat_en, bus.alu_imm, bus.alu_op} !== {2'b11, 4'd9}) begin n_fail++; $display("FAIL regim_exec: got %b want 111001", {bus.stat_en, bus.alu_imm, bus.alu_op}); end
   endtask

   task automatic test_branch();
      do_reset();
      bus.stat = 4'b0010;
      fetch_decode(4'd5, 4'b0010, 4'd0);  // BRR, taken
      n_cmp++; if (bus.retire !== 1'b0) begin n_fail++; $display("FAIL brr_decode_retire: got %b want 0", bus.retire); end
      tick();
      n_cmp++; if ({bus.pc_write, bus.pc_sel, bus.retire} !== 4'b1101) begin n_fail++; $display("FAIL brr_taken: got %b want 1101", {bus.pc_write, bus.pc_sel, bus.retire}); end
      tick();
      n_cmp++; if ({bus.mem_req, bus.retire_cnt} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL brr_next: got %b want 10001", {bus.mem_req, bus.retire_cnt}); end

      do_reset();
      bus.stat = 4'b0010;
      fetch_decode(4'd6, 4'b0010, 4'd0);  // BNE, not taken
      tick();
      n_cmp++; if ({bus.pc_write, bus.pc_sel, bus.retire} !== 4'b0001) begin n_fail++; $display("FAIL bne_not_taken: got %b want 0001", {bus.pc_write, bus.pc_sel, bus.retire}); end

      bus.stat = 4'b0100;
      fetch_decode(4'd6, 4'b0010, 4'd0);  // BNE, taken
      tick();
      n_cmp++; if ({bus.pc_write, bus.pc_sel} !== 3'b101) begin n_fail++; $display("FAIL bne_taken: got %b want 101", {bus.pc_write, bus.pc_sel}); end

      bus.stat = 4'b0001;
      fetch_decode(4'd4, 4'b0010, 4'd0);  // BRA, not taken
      tick();
      n_cmp++; if ({bus.pc_write, bus.pc_sel} !== 3'b000) begin n_fail++; $display("FAIL bra_not_taken: got %b want 000", {bus.pc_write, bus.pc_sel}); end

      bus.stat = 4'b0000;
      fetch_decode(4'd9, 4'b0000, 4'd0);  // JPR always
      tick();
      n_cmp++; if ({bus.pc_write, bus.pc_sel} !== 3'b110) begin n_fail++; $display("FAIL jpr: got %b want 110", {bus.pc_write, bus.pc_sel}); end
      tick();
      n_cmp++; if (bus.retire_cnt !== 4'd4) begin n_fail++; $display("FAIL branch_cnt: got %0d want 4", bus.retire_cnt); end
   endtask

   task automatic test_lod();
      do_reset();
      fetch_decode(4'd10, 4'd0, 4'd0);   // cycles 1-2
      tick();                            // cycle 3 EXECUTE
      n_cmp++; if ({bus.alu_imm, bus.mem_req} !== 2'b10) begin n_fail++; $display("FAIL lod_exec: got %b want 10", {bus.alu_imm, bus.mem_req}); end
      tick();                            // cycle 4 MEM, no ack
      n_cmp++; if ({bus.mem_req, bus.mem_we, bus.retire} !== 3'b100) begin n_fail++; $display("FAIL lod_mem1: got %b want 100", {bus.mem_req, bus.mem_we, bus.retire}); end
      tick();                            // cycle 5 MEM, no ack
      n_cmp++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL lod_mem2: got %b want 1", bus.mem_req); end
      tick();                            // cycle 6 MEM, ack
      bus.mem_ack = 1'b1; #1;
      n_cmp++; if ({bus.mem_req, bus.mem_we, bus.retire} !== 3'b100) begin n_fail++; $display("FAIL lod_mem3: got %b want 100", {bus.mem_req, bus.mem_we, bus.retire}); end
      tick();                            // cycle 7 WB
      bus.mem_ack = 1'b0; #1;
      n_cmp++; if ({bus.rf_we, bus.wb_sel, bus.rf_wsel, bus.retire, bus.mem_req} !== 5'b11010) begin n_fail++; $display("FAIL lod_wb: got %b want 11010", {bus.rf_we, bus.wb_sel, bus.rf_wsel, bus.retire, bus.mem_req}); end
      tick();
      n_cmp++; if ({bus.mem_req, bus.retire_cnt} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL lod_next: got %b want 10001", {bus.mem_req, bus.retire_cnt}); end
   endtask

   task automatic test_str();
      do_reset();
      fetch_decode(4'd11, 4'd0, 4'd0);
      tick();                            // EXECUTE
      n_cmp++; if ({bus.alu_imm, bus.mem_we} !== 2'b10) begin n_fail++; $display("FAIL str_exec: got %b want 10", {bus.alu_imm, bus.mem_we}); end
      tick();                            // MEM, acked
      bus.mem_ack = 1'b1; #1;
      n_cmp++; if ({bus.mem_req, bus.mem_we, bus.rf_we, bus.retire} !== 4'b1101) begin n_fail++; $display("FAIL str_mem: got %b want 1101", {bus.mem_req, bus.mem_we, bus.rf_we, bus.retire}); end
      tick();                            // FETCH
      bus.mem_ack = 1'b0; #1;
      n_cmp++; if ({bus.mem_req, bus.mem_we, bus.rf_we, bus.retire_cnt} !== {3'b100, 4'd1}) begin n_fail++; $display("FAIL str_next: got %b want 1000001", {bus.mem_req, bus.mem_we, bus.rf_we, bus.retire_cnt}); end
   endtask

   task automatic test_swap();
      do_reset();
      fetch_decode(4'd3, 4'd0, 4'd0);
      tick();                            // EXECUTE
      n_cmp++; if ({bus.rf_we, bus.retire} !== 2'b00) begin n_fail++; $display("FAIL swap_exec: got %b want 00", {bus.rf_we, bus.retire}); end
      tick();                            // WB
      n_cmp++; if ({bus.rf_we, bus.rf_wsel, bus.retire} !== 3'b100) begin n_fail++; $display("FAIL swap_wb: got %b want 100", {bus.rf_we, bus.rf_wsel, bus.retire}); end
      tick();                            // WB2
      n_cmp++; if ({bus.rf_we, bus.rf_wsel, bus.retire} !== 3'b111) begin n_fail++; $display("FAIL swap_wb2: got %b want 111", {bus.rf_we, bus.rf_wsel, bus.retire}); end
      tick();
      n_cmp++; if ({bus.mem_req, bus.retire_cnt} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL swap_cnt: got %b want 10001", {bus.mem_req, bus.retire_cnt}); end
   endtask

   task automatic test_timeout();
      int bad;
      do_reset();
      tick();                            // first FETCH cycle
      bad = 0;
      for (int i = 0; i < 16; i++) begin
         if (bus.mem_req !== 1'b1 || bus.fault !== 1'b0) bad++;
         tick();
      end
      n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL timeout_fetch_hold: got %0d bad cycles want 0", bad); end
      n_cmp++; if ({bus.fault, bus.mem_req, bus.halted} !== 3'b100) begin n_fail++; $display("FAIL timeout_fault: got %b want 100", {bus.fault, bus.mem_req, bus.halted}); end
      bus.mem_ack = 1'b1;
      repeat (3) tick();
      n_cmp++; if ({bus.fault, bus.ir_load} !== 2'b10) begin n_fail++; $display("FAIL timeout_sticky: got %b want 10", {bus.fault, bus.ir_load}); end
      bus.mem_ack = 1'b0;
   endtask

   task automatic test_illegal();
      do_reset();
      fetch_decode(4'd13, 4'd0, 4'd0);
      tick();
      n_cmp++; if ({bus.fault, bus.halted, bus.retire, bus.mem_req} !== 4'b1000) begin n_fail++; $display("FAIL illegal13: got %b want 1000", {bus.fault, bus.halted, bus.retire, bus.mem_req}); end
      do_reset();
      fetch_decode(4'd12, 4'd0, 4'd0);
      tick();
      n_cmp++; if (bus.fault !== 1'b1) begin n_fail++; $display("FAIL illegal12: got %b want 1", bus.fault); end
   endtask

   task automatic test_hlt();
      do_reset();
      fetch_decode(4'd0, 4'd0, 4'd0);
      tick();                            // NOOP EXECUTE
      n_cmp++; if (bus.retire !== 1'b1) begin n_fail++; $display("FAIL noop_retire: got %b want 1", bus.retire); end
      fetch_decode(4'd15, 4'd0, 4'd0);
      tick();
      n_cmp++; if ({bus.halted, bus.fault, bus.retire, bus.mem_req, bus.retire_cnt} !== {4'b1000, 4'd1}) begin n_fail++; $display("FAIL hlt: got %b want 10000001", {bus.halted, bus.fault, bus.retire, bus.mem_req, bus.retire_cnt}); end
      bus.mem_ack = 1'b1;
      repeat (3) tick();
      n_cmp++; if ({bus.halted, bus.retire_cnt} !== {1'b1, 4'd1}) begin n_fail++; $display("FAIL hlt_stays: got %b want 10001", {bus.halted, bus.retire_cnt}); end
      bus.mem_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      fetch_decode(4'd0, 4'd0, 4'd0);
      tick();                            // NOOP retires
      fetch_decode(4'd11, 4'd0, 4'd0);
      tick();                            // STR EXECUTE
      tick();                            // STR MEM, waiting
      n_cmp++; if ({bus.mem_req, bus.mem_we, bus.retire_cnt} !== {2'b11, 4'd1}) begin n_fail++; $display("FAIL midrst_before: got %b want 110001", {bus.mem_req, bus.mem_we, bus.retire_cnt}); end
      rst_f = 1'b1;
      bus.mem_ack = 1'b1;
      tick();
      n_cmp++; if ({bus.mem_req, bus.mem_we, bus.retire, bus.retire_cnt} !== {3'b000, 4'd0}) begin n_fail++; $display("FAIL midrst_after: got %b want 0000000", {bus.mem_req, bus.mem_we, bus.retire, bus.retire_cnt}); end
      rst_f = 1'b0;
      bus.mem_ack = 1'b0;
      tick();
      n_cmp++; if ({bus.mem_req, bus.fault} !== 2'b10) begin n_fail++; $display("FAIL midrst_restart: got %b want 10", {bus.mem_req, bus.fault}); end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 15; i++) begin
         fetch_decode(4'd0, 4'd0, 4'd0);
         tick();
      end
      fetch_decode(4'd0, 4'd0, 4'd0);
      n_cmp++; if (bus.retire_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d want 15", bus.retire_cnt); end
      tick();
      tick();
      n_cmp++; if (bus.retire_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_0: got %0d want 0", bus.retire_cnt); end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst_f  = 1'b1;
      bus.opcode = '0; bus.mm = '0; bus.func = '0; bus.stat = '0; bus.mem_ack = 1'b0;
      test_reset();
      test_reg_op();
      test_reg_im();
      test_branch();
      test_lod();
      test_str();
      test_swap();
      test_timeout();
      test_illegal();
      test_hlt();
      test_reset_mid();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "bench did not complete");
   end
endmodule

// File: doc/sisc_ctrl_mc.md
# sisc_ctrl_mc

Parametrised multicycle control FSM for the SISC processor, replacing the fixed five-step sequencer. It adds a wait-state memory handshake with a timeout, conditional branches and jumps driven by the status mask, LOD/STR sequencing and two-cycle SWAP writeback. HLT and illegal opcodes go to terminal HALT and FAULT states. It sits between the instruction register/status register and the datapath (PC, RF, ALU, memory port).

## Interface
- OP_W, 4: opcode width
- MM_W, 4: mode/mask field width; equals STAT_W
- STAT_W, 4: status flag width
- FN_W, 4: ALU function field width
- MEM_TIMEOUT, 15: cycles without mem_ack before FAULT; 0 disables the timeout
- CNT_W, 16: retired-instruction counter width
- clk  input  1  clock; all state changes on the rising edge
- rst_f  input  1  reset, synchronous, active-high
- opcode  input  OP_W  IR opcode, valid from DECODE
- mm  input  MM_W  IR mask field
- func  input  FN_W  IR ALU function field
- stat  input  STAT_W  status register
- mem_ack  input  1  memory transfer complete, sampled each cycle
- ir_load, pc_write, stat_en, rf_we, rf_wsel, alu_imm, mem_req, mem_we  output  1 each  datapath strobes
- wb_sel  output  1  RF write source: 0 = ALU, 1 = memory
- pc_sel  output  2  0 = pc+1, 1 = absolute immediate, 2 = pc+immediate
- alu_op  output  FN_W  ALU operation
- halted, fault, retire  output  1 each  status/pulse
- retire_cnt  output  CNT_W  count of retired instructions

## Operation
- States: START, FETCH, DECODE, EXECUTE, MEM, WB, WB2, HALT, FAULT.
- Opcodes: NOOP 0, REG_OP 1, REG_IM 2, SWAP 3, BRA 4, BRR 5, BNE 6, BNR 7, JPA 8, JPR 9, LOD 10, STR 11, HLT 15. Opcodes 12–14 are illegal.
- START -> FETCH unconditionally.
- FETCH: mem_req=1 and mem_we=0 every cycle in the state. The first cycle with mem_ack=1 drives ir_load=1, pc_write=1, pc_sel=0, then goes to DECODE.
- DECODE: latch opcode, mm and func into internal registers. HLT -> HALT; illegal opcode -> FAULT; all others -> EXECUTE. Every later state uses the latched copies.
- EXECUTE:
  - REG_OP and REG_IM: alu_op=func, stat_en=1; alu_imm=1 for REG_IM only; next state WB.
  - SWAP: next state WB.
  - LOD and STR: alu_imm=1 (address), next state MEM.
  - Branch taken condition: BRA/BRR when (stat & mm) != 0; BNE/BNR when (stat & mm) == 0; JPA/JPR always. If taken, pc_write=1 with pc_sel=1 (BRA, BNE, JPA) or pc_sel=2 (BRR, BNR, JPR). Branches, jumps and NOOP retire here and go to FETCH.
- MEM: mem_req=1 every cycle in the state; mem_we=1 for STR. On mem_ack, LOD -> WB and STR retires -> FETCH.
- WB: rf_we=1, rf_wsel=0; wb_sel=1 for LOD, else 0. SWAP -> WB2; all others retire -> FETCH.
- WB2: rf_we=1, rf_wsel=1, retire -> FETCH.
- Retire: retire=1 for one cycle in the retiring state; retire_cnt increments on that edge and wraps modulo 2^CNT_W. HLT and faulted instructions never retire.
- HALT: halted=1, all strobes 0, stays until reset.
- FAULT: fault=1, all strobes 0, stays until reset.
- Timeout: a wait counter clears on entry to FETCH or MEM. It increments each cycle mem_ack=0. When it reaches MEM_TIMEOUT with mem_ack still 0 (MEM_TIMEOUT > 0), next state is FAULT. mem_ack takes priority in the same cycle.
- Any output not listed for a state is 0.

## Timing
- Outputs are Moore/Mealy combinational from state, latched fields, stat and mem_ack. No registered outputs except retire_cnt.
- Reset: rst_f=1 at an edge sets state START, retire_cnt 0 and clears latched fields and the wait counter. All outputs are 0 while in START. Reset overrides everything, including mid-transfer; mem_req drops in the cycle after the reset edge.
- Cycles per instruction with a same-cycle ack:
  - NOOP, branch, jump: 3
  - REG_OP, REG_IM, STR: 4
  - LOD, SWAP: 5
  - Each cycle of ack delay adds one cycle.
- First FETCH cycle is 2 cycles after the edge that deasserts rst_f.
- mem_ack outside FETCH/MEM is ignored.

## Test plan
- Reset held 3 cycles, then REG_OP func=4, ack immediate -> mem_req cycle 1; rf_we=1 exactly in cycle 4 with alu_op=4; stat_en=1 in cycle 3; retire_cnt=1.
- BRR with stat=4'b0010 and mm=4'b0010 -> pc_write and pc_sel=2 in EXECUTE. BNE with the same values -> no pc_write in EXECUTE; retires in 3 cycles.
- LOD with ack delayed 2 cycles in MEM -> mem_req held 3 cycles, mem_we=0, then WB with wb_sel=1; 7 cycles total. STR -> mem_we=1, no rf_we.
- SWAP -> WB with rf_wsel=0, then WB2 with rf_wsel=1, both rf_we=1; retire once.
- MEM_TIMEOUT=15 with no ack in FETCH -> FAULT after 16 FETCH cycles; fault=1 stays set. Opcode 13 -> FAULT from DECODE. HLT -> halted=1, retire_cnt unchanged.
- rst_f asserted during MEM of STR -> next cycle mem_req=0, state START, retire_cnt=0. Also run 2^CNT_W retires with CNT_W=4 -> counter wraps to 0.
